// File: rtl/fd_de_pipe_regs_if.sv
// Hazard-controller, decoder and E-stage signals around the fetch/decode/execute pipeline registers.
// The master side drives PC, instruction, control and decoded fields; the slave side is the register block.
interface fd_de_pipe_regs_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic [XLEN-1:0]  pc_next;
  logic [31:0]      instrF;
  logic             stallF;
  logic             stallD;
  logic             flushD;
  logic             flushE;
  logic [4:0]       rs1_addrD;
  logic [4:0]       rs2_addrD;
  logic [4:0]       rd_addrD;
  logic             rd_wr_enD;
  logic [1:0]       wb_selD;
  logic             br_enD;
  logic [XLEN-1:0]  rs1_dataD;
  logic [XLEN-1:0]  rs2_dataD;
  logic [XLEN-1:0]  immD;

  logic [XLEN-1:0]  pcF;
  logic [XLEN-1:0]  pcD;
  logic [31:0]      instrD;
  logic             validD;
  logic [XLEN-1:0]  pcE;
  logic [4:0]       rs1_addrE;
  logic [4:0]       rs2_addrE;
  logic [4:0]       rd_addrE;
  logic             rd_wr_enE;
  logic [1:0]       wb_selE;
  logic             br_enE;
  logic [XLEN-1:0]  rs1_dataE;
  logic [XLEN-1:0]  rs2_dataE;
  logic [XLEN-1:0]  immE;
  logic             validE;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output pc_next, instrF, stallF, stallD, flushD, flushE,
           rs1_addrD, rs2_addrD, rd_addrD, rd_wr_enD, wb_selD, br_enD,
           rs1_dataD, rs2_dataD, immD,
    input  pcF, pcD, instrD, validD, pcE, rs1_addrE, rs2_addrE, rd_addrE,
           rd_wr_enE, wb_selE, br_enE, rs1_dataE, rs2_dataE, immE, validE,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  pc_next, instrF, stallF, stallD, flushD, flushE,
           rs1_addrD, rs2_addrD, rd_addrD, rd_wr_enD, wb_selD, br_enD,
           rs1_dataD, rs2_dataD, immD,
    output pcF, pcD, instrD, validD, pcE, rs1_addrE, rs2_addrE, rd_addrE,
           rd_wr_enE, wb_selE, br_enE, rs1_dataE, rs2_dataE, immE, validE,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/fd_de_pipe_regs.sv
// PC, F/D and D/E pipeline registers with hold/bubble control and stall/flush event counters.
// One-cycle register stages; there is no backpressure -- the hazard controller stalls or flushes directly.
module fd_de_pipe_regs #(
  parameter int               XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_PC  = '0,
  parameter logic [31:0]      NOP_INSTR = 32'h0000_0013,
  parameter int               CNT_W     = 32
) (
  input  logic               clk,
  input  logic               rst,
  fd_de_pipe_regs_if.slave   bus
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [4:0]      rd_addr;
    logic            rd_wr_en;
    logic [1:0]      wb_sel;
    logic            br_en;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic            valid;
  } de_t;

  logic [XLEN-1:0]  pcf_q, pcf_d;
  logic [XLEN-1:0]  pcd_q, pcd_d;
  logic [31:0]      instrd_q, instrd_d;
  logic             validd_q, validd_d;
  de_t              de_q, de_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    pcf_d       = pcf_q;
    pcd_d       = pcd_q;
    instrd_d    = instrd_q;
    validd_d    = validd_q;
    de_d        = de_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    // A redirect (flushD) must never be lost behind a fetch stall.
    if (!bus.stallF || bus.flushD) begin
      pcf_d = bus.pc_next;
    end

    if (bus.flushD) begin
      pcd_d    = '0;
      instrd_d = NOP_INSTR;
      validd_d = 1'b0;
    end else if (!bus.stallD) begin
      pcd_d    = pcf_q;
      instrd_d = bus.instrF;
      validd_d = 1'b1;
    end

    if (bus.flushE) begin
      de_d = '0;
    end else begin
      de_d.pc       = pcd_q;
      de_d.rs1_addr = bus.rs1_addrD;
      de_d.rs2_addr = bus.rs2_addrD;
      de_d.rd_addr  = bus.rd_addrD;
      de_d.rd_wr_en = bus.rd_wr_enD;
      de_d.wb_sel   = bus.wb_selD;
      de_d.br_en    = bus.br_enD;
      de_d.rs1_data = bus.rs1_dataD;
      de_d.rs2_data = bus.rs2_dataD;
      de_d.imm      = bus.immD;
      de_d.valid    = validd_q;
    end

    if (bus.stallD) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (bus.flushD || bus.flushE) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcf_q       <= RESET_PC;
      pcd_q       <= '0;
      instrd_q    <= NOP_INSTR;
      validd_q    <= 1'b0;
      de_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      pcf_q       <= pcf_d;
      pcd_q       <= pcd_d;
      instrd_q    <= instrd_d;
      validd_q    <= validd_d;
      de_q        <= de_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.pcF       = pcf_q;
  assign bus.pcD       = pcd_q;
  assign bus.instrD    = instrd_q;
  assign bus.validD    = validd_q;
  assign bus.pcE       = de_q.pc;
  assign bus.rs1_addrE = de_q.rs1_addr;
  assign bus.rs2_addrE = de_q.rs2_addr;
  assign bus.rd_addrE  = de_q.rd_addr;
  assign bus.rd_wr_enE = de_q.rd_wr_en;
  assign bus.wb_selE   = de_q.wb_sel;
  assign bus.br_enE    = de_q.br_en;
  assign bus.rs1_dataE = de_q.rs1_data;
  assign bus.rs2_dataE = de_q.rs2_data;
  assign bus.immE      = de_q.imm;
  assign bus.validE    = de_q.valid;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_fd_de_pipe_regs.sv
// Directed bench for fd_de_pipe_regs: stimulus queues hand-computed expectations, a monitor pops and compares.
module tb_fd_de_pipe_regs;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  typedef enum int {
    PCF, PCD, INSTRD, VALIDD, PCE, RS1E, RS2E, RDE, RDWE, WBSEL, BREN,
    RS1DATAE, RS2DATAE, IMME, VALIDE, STALLCNT, FLUSHCNT
  } fld_e;

  typedef struct {
    fld_e        f;
    logic [31:0] v;
  } exp_t;

  logic clk;
  logic rst;
  exp_t q[$];
  event chk_ev;
  int   n_chk = 0;
  int   n_err = 0;

  fd_de_pipe_regs_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  fd_de_pipe_regs #(
    .XLEN(XLEN), .RESET_PC(32'h0), .NOP_INSTR(32'h13), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] peek(input fld_e f);
    case (f)
      PCF:      return bus.pcF;
      PCD:      return bus.pcD;
      INSTRD:   return bus.instrD;
      VALIDD:   return 32'(bus.validD);
      PCE:      return bus.pcE;
      RS1E:     return 32'(bus.rs1_addrE);
      RS2E:     return 32'(bus.rs2_addrE);
      RDE:      return 32'(bus.rd_addrE);
      RDWE:     return 32'(bus.rd_wr_enE);
      WBSEL:    return 32'(bus.wb_selE);
      BREN:     return 32'(bus.br_enE);
      RS1DATAE: return bus.rs1_dataE;
      RS2DATAE: return bus.rs2_dataE;
      IMME:     return bus.immE;
      VALIDE:   return 32'(bus.validE);
      STALLCNT: return 32'(bus.stall_cnt);
      FLUSHCNT: return 32'(bus.flush_cnt);
      default:  return 32'hxxxx_xxxx;
    endcase
  endfunction

  // Monitor: drains every expectation queued for the current sample point.
  initial begin
    forever begin
      @(chk_ev);
      while (q.size() > 0) begin
        exp_t e;
        logic [31:0] act;
        e   = q.pop_front();
        act = peek(e.f);
        n_chk++;
        if (act !== e.v) begin
          n_err++;
          $display("FAIL %s: got %h, expected %h", e.f.name(), act, e.v);
        end
      end
    end
  end

  task automatic ex(input fld_e f, input logic [31:0] v);
    exp_t e;
    e.f = f;
    e.v = v;
    q.push_back(e);
  endtask

  task automatic chk();
    -> chk_ev;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic sf, input logic sd, input logic fd, input logic fe,
                     input logic [31:0] pcn, input logic [31:0] ins);
    bus.stallF  = sf;
    bus.stallD  = sd;
    bus.flushD  = fd;
    bus.flushE  = fe;
    bus.pc_next = pcn;
    bus.instrF  = ins;
  endtask

  task automatic dec(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                     input logic we, input logic [1:0] wb, input logic br,
                     input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm);
    bus.rs1_addrD = r1;
    bus.rs2_addrD = r2;
    bus.rd_addrD  = rd;
    bus.rd_wr_enD = we;
    bus.wb_selD   = wb;
    bus.br_enD    = br;
    bus.rs1_dataD = d1;
    bus.rs2_dataD = d2;
    bus.immD      = imm;
  endtask

  task automatic ex_reset_state();
    ex(PCF, 32'h0); ex(INSTRD, 32'h13); ex(PCD, 32'h0); ex(VALIDD, 0);
    ex(VALIDE, 0); ex(PCE, 0); ex(RDWE, 0); ex(WBSEL, 0); ex(BREN, 0); ex(RDE, 0);
    ex(STALLCNT, 0); ex(FLUSHCNT, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected stimulus completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drv(0, 0, 0, 0, 32'h40, 32'h0);
    dec(0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    #2;
    ex_reset_state();
    chk();

    // Straight-line flow from PC 0.
    drv(0, 0, 0, 0, 32'h4, 32'h0050_0093);
    rst = 1'b0;
    step();
    ex(PCF, 32'h4); ex(PCD, 32'h0); ex(INSTRD, 32'h0050_0093); ex(VALIDD, 1); ex(VALIDE, 0);
    chk();

    drv(0, 0, 0, 0, 32'h8, 32'h00A0_0113);
    dec(0, 5, 1, 1, 2'b00, 0, 0, 0, 32'h5);
    step();
    ex(PCF, 32'h8); ex(PCD, 32'h4); ex(INSTRD, 32'h00A0_0113); ex(VALIDD, 1);
    ex(PCE, 32'h0); ex(RDE, 1); ex(RDWE, 1); ex(IMME, 32'h5); ex(VALIDE, 1);
    chk();

    // Load-use: PC and F/D hold, E gets a bubble.
    drv(1, 1, 0, 1, 32'hC, 32'h0);
    dec(3, 4, 2, 1, 2'b01, 0, 32'h11, 32'h22, 32'hA);
    step();
    ex(PCF, 32'h8); ex(PCD, 32'h4); ex(INSTRD, 32'h00A0_0113); ex(VALIDD, 1);
    ex(VALIDE, 0); ex(WBSEL, 0); ex(RDE, 0); ex(RDWE, 0);
    ex(STALLCNT, 1); ex(FLUSHCNT, 1);
    chk();

    drv(0, 0, 0, 0, 32'hC, 32'h00C0_0193);
    step();
    ex(PCE, 32'h4); ex(RS1E, 3); ex(RS2E, 4); ex(RDE, 2); ex(RDWE, 1); ex(WBSEL, 1);
    ex(RS1DATAE, 32'h11); ex(RS2DATAE, 32'h22); ex(IMME, 32'hA); ex(VALIDE, 1);
    ex(PCF, 32'hC); ex(PCD, 32'h8); ex(INSTRD, 32'h00C0_0193);
    ex(STALLCNT, 1); ex(FLUSHCNT, 1);
    chk();

    // Taken branch: both stages bubble, one flush event.
    drv(0, 0, 1, 1, 32'h100, 32'h1234_5678);
    dec(1, 2, 3, 1, 2'b10, 1, 32'h1, 32'h2, 32'h3);
    step();
    ex(PCF, 32'h100); ex(INSTRD, 32'h13); ex(PCD, 0); ex(VALIDD, 0);
    ex(VALIDE, 0); ex(RDWE, 0); ex(BREN, 0); ex(PCE, 0);
    ex(FLUSHCNT, 2); ex(STALLCNT, 1);
    chk();

    drv(0, 0, 0, 0, 32'h104, 32'h0010_0073);
    dec(0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    step();
    ex(PCF, 32'h104); ex(PCD, 32'h100); ex(INSTRD, 32'h0010_0073); ex(VALIDD, 1); ex(VALIDE, 0);
    chk();

    // Flush beats both stalls.
    drv(1, 1, 1, 0, 32'h200, 32'hDEAD_BEEF);
    dec(5, 6, 7, 1, 2'b11, 1, 32'hA, 32'hB, 32'hC);
    step();
    ex(PCF, 32'h200); ex(INSTRD, 32'h13); ex(PCD, 0); ex(VALIDD, 0);
    ex(VALIDE, 1); ex(PCE, 32'h100); ex(RDE, 7); ex(BREN, 1); ex(WBSEL, 3);
    ex(STALLCNT, 2); ex(FLUSHCNT, 3);
    chk();

    drv(1, 0, 0, 0, 32'h300, 32'h1111_1111);
    dec(0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    step();
    ex(PCF, 32'h200); ex(PCD, 32'h200); ex(INSTRD, 32'h1111_1111); ex(VALIDD, 1);
    ex(VALIDE, 0); ex(STALLCNT, 2);
    chk();

    // Asynchronous reset mid-cycle.
    drv(0, 1, 0, 0, 32'h40, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    ex_reset_state();
    chk();
    drv(0, 0, 0, 0, 32'h40, 32'h0050_0093);
    rst = 1'b0;
    step();
    ex(PCF, 32'h40); ex(PCD, 0); ex(INSTRD, 32'h0050_0093); ex(VALIDD, 1);
    ex(STALLCNT, 0); ex(FLUSHCNT, 0);
    chk();

    // Counter wrap at CNT_W=4.
    drv(1, 1, 0, 0, 32'h44, 32'h0);
    repeat (16) step();
    ex(STALLCNT, 0); ex(PCF, 32'h40); ex(INSTRD, 32'h0050_0093); ex(FLUSHCNT, 0);
    chk();
    step();
    ex(STALLCNT, 1); ex(FLUSHCNT, 0);
    chk();

    #2;
    n_chk++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drain: got %0d pending, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
